present_iter_ctrl: RTL and testbench

//  Iterative PRESENT-80 encryption engine controller. Accepts one 64-bit plaintext and 80-bit key

---
 rtl/present_pkg.sv | 24 ++
 rtl/present_round_core.sv | 14 +
 rtl/present_iter_ctrl.sv | 76 +++++++
 tb/tb_present_iter_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 types, S-box table, P-layer and key schedule
package present_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  function automatic logic [63:0] s_layer(input logic [63:0] d);
    logic [63:0] s;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = SBOX[d[4*i +: 4]];
    return s;
  endfunction
  function automatic logic [63:0] p_layer(input logic [63:0] d);
    logic [63:0] o;
    o[63] = d[63];
    for (int i = 0; i < 63; i++) o[(16 * i) % 63] = d[i];
    return o;
  endfunction
  function automatic logic [79:0] keysched(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = SBOX[n[79:76]];
    n[19:15] = n[19:15] ^ r;
    return n;
  endfunction
endpackage

// File: rtl/present_round_core.sv
// present_round_core: one combinational PRESENT-80 round (add key, S-layer, P-layer, key update)
// ports: dreg/kreg/rnd current state and round counter; next_dreg/next_kreg next state
module present_round_core
  import present_pkg::*;
(
  input  logic [63:0] dreg,
  input  logic [79:0] kreg,
  input  logic [4:0]  rnd,
  output logic [63:0] next_dreg,
  output logic [79:0] next_kreg
);
  assign next_dreg = p_layer(s_layer(dreg ^ kreg[79:16]));
  assign next_kreg = keysched(kreg, rnd);
endmodule

// File: rtl/present_iter_ctrl.sv
// present_iter_ctrl: iterative PRESENT-80 encryption controller with valid/ready handshakes
// ports: clk, reset (async active-low); in_valid/in_ready/in_data/in_key block input;
//        out_valid/out_ready/out_data ciphertext output; busy, round_idx status
module present_iter_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [4:0]  round_idx
);
  localparam logic [4:0] LAST = 5'(ROUNDS);
  state_e      state_q;
  logic [63:0] dreg_q, out_data_q, next_dreg, out_data_d;
  logic [79:0] kreg_q, next_kreg;
  logic [4:0]  rnd_q;
  logic        out_valid_q, accept;
  present_round_core u_core (
    .dreg(dreg_q),
    .kreg(kreg_q),
    .rnd(rnd_q),
    .next_dreg(next_dreg),
    .next_kreg(next_kreg)
  );
  // final whitening uses the key produced by the last round's schedule step
  assign out_data_d = next_dreg ^ next_kreg[79:16];
  assign in_ready   = reset & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept     = in_valid & in_ready;
  assign busy       = state_q == RUN;
  assign round_idx  = busy ? rnd_q : 5'd0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      dreg_q      <= '0;
      kreg_q      <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          dreg_q <= next_dreg;
          kreg_q <= next_kreg;
          rnd_q  <= rnd_q + 5'd1;
          if (rnd_q == LAST) begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: ;
      endcase
      // accepting overrides the DONE exit so back-to-back blocks skip IDLE
      if (accept) begin
        dreg_q  <= in_data;
        kreg_q  <= in_key;
        rnd_q   <= 5'd1;
        state_q <= RUN;
      end
    end
endmodule

// File: tb/tb_present_iter_ctrl.sv
// tb_present_iter_ctrl: scoreboard bench for present_iter_ctrl against a PRESENT-80 reference model
module tb_present_iter_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, in_ready, out_valid, busy;
  logic [63:0] in_data, out_data;
  logic [79:0] in_key;
  logic [4:0]  round_idx;
  typedef struct {logic [63:0] d; int acc;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0, cyc = 0, mode = 0, last_rise = -1;
  bit stream = 0;
  int sb_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  localparam logic [63:0] ONES64 = {64{1'b1}};
  localparam logic [79:0] ONES80 = {80{1'b1}};

  present_iter_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .round_idx(round_idx)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PRESENT-80 from the cipher description: whole-word shifts, table lookups, bit permutation
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb_tab[s[4*n +: 4]]);
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      k = (k << 61) | (k >> 19);
      k[79:76] = 4'(sb_tab[k[79:76]]);
      k = k ^ (80'(r) << 15);
    end
    return s ^ k[79:16];
  endfunction

  // sink: out_ready policy 0=always high, 1=random, 2=held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // monitor: hold/stability, latency, interval, status invariants, data compare on handshake
  initial begin
    bit pv, ph;
    logic [63:0] pd;
    exp_t e;
    pv = 0; ph = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 0; ph = 0;
      end else begin
        if (pv && !ph) begin
          chk("hold_valid", 80'(out_valid), 80'(1));
          chk("hold_data", 80'(out_data), 80'(pd));
        end
        if (out_valid && !pv) begin
          if (sb.size() == 0) chk("unexpected_valid", 80'(out_valid), 80'(0));
          else chk("latency", 80'(cyc - sb[0].acc), 80'(31));
          if (stream && last_rise >= 0) chk("interval", 80'(cyc - last_rise), 80'(32));
          last_rise = cyc;
        end
        if (stream && (sb.size() > 0 || out_valid)) chk("busy_vs_done", 80'(busy), 80'(!out_valid));
        if (busy) chk("round_idx_range", 80'(round_idx >= 1 && round_idx <= 31), 80'(1));
        else chk("round_idx_zero", 80'(round_idx), 80'(0));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_handshake", 80'(1), 80'(0));
          else begin
            e = sb.pop_front();
            chk("out_data", 80'(out_data), 80'(e.d));
          end
        end
        pv = out_valid; ph = out_valid && out_ready; pd = out_data;
      end
    end
  end

  // call at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic send(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; in_data = pt; in_key = key;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 80'(in_ready), 80'(1));
    else begin
      e.d = exp; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain", 80'(sb.size()), 80'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [63:0] pt;
    logic [79:0] key;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_data", 80'(out_data), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    drain();
    send(64'h0, ONES80, 64'hE72C46C0F5945049);
    drain();
    mode = 2;
    send(ONES64, 80'h0, 64'hA112FFC72F68417B);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("hold_reached", 80'(out_valid), 80'(1));
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", 80'(in_ready), 80'(0));
    end
    mode = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      send(ONES64, ONES80, 64'h3333DCD3213210D2);
      if (i == 0) begin stream = 1; last_rise = -1; end
    end
    drain();
    stream = 0;
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    n = 0;
    while (round_idx != 5'd15 && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_round15", 80'(round_idx), 80'(15));
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 80'(out_valid), 80'(0));
    chk("mid_rst_out_data", 80'(out_data), 80'(0));
    chk("mid_rst_busy", 80'(busy), 80'(0));
    chk("mid_rst_round_idx", 80'(round_idx), 80'(0));
    chk("mid_rst_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    drain();
    pt = {$urandom, $urandom};
    key = 80'({$urandom, $urandom, $urandom});
    send(pt, key, ref_enc(pt, key));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("run_in_ready", 80'(in_ready), 80'(0));
      @(posedge clk); #1;
      in_data = {$urandom, $urandom};
      in_key = 80'({$urandom, $urandom, $urandom});
      in_valid = (round_idx < 5'd31) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    in_valid = 1'b0;
    drain();
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      pt = {$urandom, $urandom};
      key = 80'({$urandom, $urandom, $urandom});
      send(pt, key, ref_enc(pt, key));
    end
    drain();
    mode = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
